// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES-128 types, controller states, round constants and S-box
package aes_pkg;

    typedef logic [127:0] aes_state_t;

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } ctrl_state_t;

    localparam int NR = 10;

    // Forward S-box, entry 0 in the top byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] rcon(input logic [3:0] rcnt);
        logic [7:0] r;
        case (rcnt)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/aes_key_expand_round.sv
// rtl/aes_key_expand_round.sv - one AES-128 key schedule step (RotWord/SubWord/XOR chain)
module aes_key_expand_round
    import aes_pkg::*;
(
    input  aes_state_t  key_in,
    input  logic [7:0]  rcon_in,
    output aes_state_t  key_out
);

    logic [31:0] w0, w1, w2, w3, temp, n0, n1, n2, n3;

    assign {w0, w1, w2, w3} = key_in;
    assign temp = {sbox(w3[23:16]) ^ rcon_in, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    assign n0 = w0 ^ temp;
    assign n1 = w1 ^ n0;
    assign n2 = w2 ^ n1;
    assign n3 = w3 ^ n2;
    assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/mix_columns.sv
// rtl/mix_columns.sv - GF(2^8) column mixing with the fixed 02 03 01 01 matrix
module mix_columns
    import aes_pkg::*;
(
    input  aes_state_t din,
    output aes_state_t dout
);

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    for (genvar c = 0; c < 4; c++) begin : g_col
        logic [7:0] a0, a1, a2, a3;
        assign {a0, a1, a2, a3} = din[127-32*c -: 32];
        assign dout[127-32*c -: 32] = {
            xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
        };
    end

endmodule

// File: rtl/shift_rows.sv
// rtl/shift_rows.sv - cyclic left shift of state row r by r bytes
module shift_rows
    import aes_pkg::*;
(
    input  aes_state_t din,
    output aes_state_t dout
);

    // Byte n = 4*col + row sits at [127-8n -: 8].
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign dout[127-8*(4*c+r) -: 8] = din[127-8*(4*((c+r)%4)+r) -: 8];
        end
    end

endmodule

// File: rtl/sub_bytes.sv
// rtl/sub_bytes.sv - byte-wise S-box substitution over the 128-bit state
module sub_bytes
    import aes_pkg::*;
(
    input  aes_state_t din,
    output aes_state_t dout
);

    for (genvar i = 0; i < 16; i++) begin : g_byte
        assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
    end

endmodule

// File: rtl/aes128_round_ctrl.sv
// rtl/aes128_round_ctrl.sv - iterative AES-128 encryptor, one round per cycle, on-the-fly key schedule
module aes128_round_ctrl
    import aes_pkg::*;
#(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] ciphertext,
    output logic [3:0]   round,
    output logic         busy
);

    if (NR != aes_pkg::NR) begin : g_nr_check
        $error("aes128_round_ctrl supports only NR=10");
    end

    ctrl_state_t fsm, fsm_nxt;
    aes_state_t  state_reg, key_reg;
    aes_state_t  sb_out, sr_out, mc_out, nk;
    logic [3:0]  rcnt;
    logic [7:0]  rcon_val;
    logic        accept, last_round;

    assign rcon_val   = rcon(rcnt);
    assign last_round = (rcnt == 4'(aes_pkg::NR));
    assign accept     = in_valid && in_ready;

    sub_bytes            u_sub_bytes   (.din(state_reg), .dout(sb_out));
    shift_rows           u_shift_rows  (.din(sb_out),    .dout(sr_out));
    mix_columns          u_mix_columns (.din(sr_out),    .dout(mc_out));
    aes_key_expand_round u_key_expand  (.key_in(key_reg), .rcon_in(rcon_val), .key_out(nk));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    always_comb begin
        fsm_nxt = fsm;
        case (fsm)
            IDLE:    if (accept) fsm_nxt = ROUND;
            ROUND:   if (last_round) fsm_nxt = DONE;
            DONE:    if (out_ready) fsm_nxt = accept ? ROUND : IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    // out_ready feeds in_ready directly so DONE can overlap the next acceptance.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm)
            IDLE:    in_ready = !rst;
            ROUND:   busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready && !rst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= '0;
            key_reg   <= '0;
            rcnt      <= 4'd0;
        end else if (accept) begin
            state_reg <= plaintext ^ key;
            key_reg   <= key;
            rcnt      <= 4'd1;
        end else if (fsm == ROUND) begin
            state_reg <= (last_round ? sr_out : mc_out) ^ nk;
            key_reg   <= nk;
            rcnt      <= last_round ? 4'd0 : rcnt + 4'd1;
        end
    end

    assign ciphertext = state_reg;
    assign round      = rcnt;

endmodule

// File: tb/tb_aes128_round_ctrl.sv
// tb/tb_aes128_round_ctrl.sv - self-checking bench for aes128_round_ctrl against a byte-level AES model
module tb_aes128_round_ctrl;

    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] plaintext = '0;
    logic [127:0] key = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [127:0] ciphertext;
    logic [3:0]   round;
    logic         busy;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    logic [7:0]  sb [256];

    aes128_round_ctrl #(.NR(10)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
        .ciphertext(ciphertext), .round(round), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv;
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                  ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [4][4];
        logic [7:0]   w [44][4];
        logic [7:0]   t [4];
        logic [7:0]   a [4];
        logic [7:0]   rc, tmp;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) s[i%4][i/4] = pt[127-8*i -: 8];
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) w[i][j] = k[127-32*i-8*j -: 8];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            for (int j = 0; j < 4; j++) t[j] = w[i-1][j];
            if (i % 4 == 0) begin
                tmp = t[0];
                t[0] = sb[t[1]] ^ rc; t[1] = sb[t[2]]; t[2] = sb[t[3]]; t[3] = sb[tmp];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i][j] = w[i-4][j] ^ t[j];
        end
        for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] ^= w[c][r];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] = sb[s[r][c]];
            for (int r = 1; r < 4; r++) begin
                for (int c = 0; c < 4; c++) a[c] = s[r][(c+r)%4];
                for (int c = 0; c < 4; c++) s[r][c] = a[c];
            end
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++) begin
                    for (int r = 0; r < 4; r++) a[r] = s[r][c];
                    for (int r = 0; r < 4; r++)
                        s[r][c] = gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4];
                end
            end
            for (int r = 0; r < 4; r++) for (int c = 0; c < 4; c++) s[r][c] ^= w[4*rnd+c][r];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i%4][i/4];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Returns at the falling edge following the accept edge, with in_valid dropped.
    task automatic send_block(input logic [127:0] p, input logic [127:0] k,
                              output int unsigned acc, output bit ok);
        @(negedge clk);
        in_valid = 1'b1; plaintext = p; key = k;
        #1;
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (in_ready) ok = 1'b1;
            else begin @(negedge clk); #1; end
        end
        @(posedge clk); #1;
        acc = cyc;
        @(negedge clk);
        in_valid = 1'b0; plaintext = rand128(); key = rand128();
    endtask

    task automatic wait_valid(input int limit, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            #1;
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0 || ciphertext !== 128'h0) begin
            bad++;
            $display("FAIL reset_outputs: got ov=%b busy=%b round=%0d ct=%h want all zero", out_valid, busy, round, ciphertext);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL reset_release: got in_ready=%b ov=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_fips_b();
        int unsigned acc;
        bit ok, seen;
        send_block(B_PT, B_KEY, acc, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL b_accept: got no in_ready want accept"); end
        for (int k = 1; k <= 10; k++) begin
            #1;
            total++;
            if (round !== 4'(k) || busy !== 1'b1 || out_valid !== 1'b0) begin
                bad++; $display("FAIL b_round: got round=%0d busy=%b ov=%b want round=%0d busy=1 ov=0", round, busy, out_valid, k);
            end
            @(negedge clk);
        end
        wait_valid(5, seen);
        total++;
        if (!seen || cyc - acc != 10) begin
            bad++; $display("FAIL b_latency: got seen=%b cycles=%0d want 10", seen, cyc - acc);
        end
        total++;
        if (ciphertext !== B_CT) begin bad++; $display("FAIL b_ct: got %h want %h", ciphertext, B_CT); end
        total++;
        if (round !== 4'd0 || busy !== 1'b0) begin
            bad++; $display("FAIL b_done_flags: got round=%0d busy=%b want 0 0", round, busy);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++; $display("FAIL b_release: got ov=%b in_ready=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_fips_c1();
        int unsigned acc;
        bit ok, seen;
        send_block(C_PT, C_KEY, acc, ok);
        wait_valid(20, seen);
        total++;
        if (!ok || !seen || cyc - acc != 10) begin
            bad++; $display("FAIL c1_latency: got ok=%b seen=%b cycles=%0d want 10", ok, seen, cyc - acc);
        end
        total++;
        if (ciphertext !== C_CT) begin bad++; $display("FAIL c1_ct: got %h want %h", ciphertext, C_CT); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_idle_noise();
        logic [127:0] p, k, exp;
        int unsigned acc;
        bit ok, seen, glitch;
        glitch = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b0; plaintext = rand128(); key = rand128();
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0 || in_ready !== 1'b1 || ciphertext !== C_CT)
                glitch = 1'b1;
        end
        total++;
        if (glitch) begin
            bad++; $display("FAIL idle_noise: got ov=%b busy=%b round=%0d ct=%h want idle with ct=%h", out_valid, busy, round, ciphertext, C_CT);
        end
        p = rand128(); k = rand128(); exp = aes_ref(p, k);
        send_block(p, k, acc, ok);
        wait_valid(20, seen);
        total++;
        if (!ok || !seen || ciphertext !== exp) begin
            bad++; $display("FAIL idle_after_block: got %h want %h", ciphertext, exp);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int unsigned acc;
        bit ok, seen, held;
        send_block(B_PT, B_KEY, acc, ok);
        wait_valid(20, seen);
        total++;
        if (!ok || !seen) begin bad++; $display("FAIL bp_complete: got ok=%b seen=%b want 1 1", ok, seen); end
        held = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = 1'b1; plaintext = rand128(); key = rand128();
            #1;
            if (out_valid !== 1'b1 || ciphertext !== B_CT || in_ready !== 1'b0) held = 1'b0;
        end
        total++;
        if (!held) begin
            bad++; $display("FAIL bp_hold: got ov=%b ct=%h in_ready=%b want 1 %h 0", out_valid, ciphertext, in_ready, B_CT);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || round !== 4'd0) held = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!held) begin
            bad++; $display("FAIL bp_release: got ov=%b in_ready=%b round=%0d want 0 1 0", out_valid, in_ready, round);
        end
    endtask

    task automatic test_back_to_back();
        int unsigned acc_t[$];
        int unsigned out_t[$];
        logic [127:0] outs[$];
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; plaintext = C_PT; key = C_KEY;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (out_valid) begin out_t.push_back(cyc); outs.push_back(ciphertext); end
            if (in_valid && in_ready) acc_t.push_back(cyc + 1);
            @(negedge clk);
            if (acc_t.size() == 1) begin plaintext = B_PT; key = B_KEY; end
            else if (acc_t.size() >= 2) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        total++;
        if (acc_t.size() != 2 || out_t.size() != 2) begin
            bad++; $display("FAIL b2b_count: got accepts=%0d outputs=%0d want 2 2", acc_t.size(), out_t.size());
        end else begin
            total++;
            if (outs[0] !== C_CT || outs[1] !== B_CT) begin
                bad++; $display("FAIL b2b_data: got %h %h want %h %h", outs[0], outs[1], C_CT, B_CT);
            end
            total++;
            if (acc_t[1] - acc_t[0] != 11 || out_t[1] - out_t[0] != 11 || out_t[0] - acc_t[0] != 10) begin
                bad++; $display("FAIL b2b_spacing: got acc_gap=%0d out_gap=%0d lat=%0d want 11 11 10",
                                acc_t[1] - acc_t[0], out_t[1] - out_t[0], out_t[0] - acc_t[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int unsigned acc;
        bit ok, seen, quiet;
        send_block(C_PT, C_KEY, acc, ok);
        seen = 1'b0;
        for (int i = 0; i < 12 && !seen; i++) begin
            #1;
            if (round == 4'd5) seen = 1'b1;
            else @(negedge clk);
        end
        total++;
        if (!ok || !seen) begin bad++; $display("FAIL rmid_reach5: got ok=%b seen=%b want 1 1", ok, seen); end
        #1;
        rst = 1'b1;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || round !== 4'd0 || ciphertext !== 128'h0 || in_ready !== 1'b0) begin
            bad++; $display("FAIL rmid_async: got ov=%b busy=%b round=%0d ct=%h in_ready=%b want all zero",
                            out_valid, busy, round, ciphertext, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b1;
        for (int i = 0; i < 14; i++) begin
            #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        total++;
        if (!quiet) begin bad++; $display("FAIL rmid_no_pulse: got stray ov/busy want none"); end
        send_block(C_PT, C_KEY, acc, ok);
        wait_valid(20, seen);
        total++;
        if (!ok || !seen || ciphertext !== C_CT || cyc - acc != 10) begin
            bad++; $display("FAIL rmid_recover: got ct=%h cycles=%0d want %h 10", ciphertext, cyc - acc, C_CT);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [127:0] p, k, exp;
        int unsigned acc;
        int hold;
        bit ok, seen;
        for (int n = 0; n < 8; n++) begin
            p = rand128(); k = rand128(); exp = aes_ref(p, k);
            send_block(p, k, acc, ok);
            wait_valid(20, seen);
            total++;
            if (!ok || !seen || cyc - acc != 10) begin
                bad++; $display("FAIL rand_latency[%0d]: got seen=%b cycles=%0d want 10", n, seen, cyc - acc);
            end
            hold = int'($urandom_range(0, 4));
            for (int h = 0; h < hold; h++) begin @(negedge clk); #1; end
            total++;
            if (out_valid !== 1'b1 || ciphertext !== exp) begin
                bad++; $display("FAIL rand_ct[%0d]: got ov=%b ct=%h want 1 %h", n, out_valid, ciphertext, exp);
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            #1;
            total++;
            if (out_valid !== 1'b0) begin bad++; $display("FAIL rand_consume[%0d]: got ov=%b want 0", n, out_valid); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want test completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        build_sbox();
        test_reset();
        test_fips_b();
        test_fips_c1();
        test_idle_noise();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/aes128_round_ctrl.md
# aes128_round_ctrl

Iterative AES-128 encryption controller. It sequences one shared round datapath (sub_bytes → shift_rows → mix_columns → add-round-key) over 10 rounds, and generates round keys on the fly. It sits between the host-side block interface and the combinational round primitives, with valid/ready handshakes on both input and output. Throughput is one block per 11 cycles, plus back-pressure.

## Interface
Parameters:
- NR, 10, number of rounds. Only 10 (AES-128) is legal; any other value is an elaboration error.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  plaintext/key pair offered.
- in_ready  output  1  controller can accept a block.
- plaintext  input  128  column-major, MSB-first; byte 0 at [127:120].
- key  input  128  cipher key, same byte order.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  consumer accepts ciphertext.
- ciphertext  output  128  result, same byte order.
- round  output  4  current round number (0 in IDLE/DONE, 1..10 while running).
- busy  output  1  high in ROUND state.

## Operation
- FSM states: IDLE, ROUND, DONE. Encoded as an enum in the package.
- IDLE:
  - in_ready=1.
  - On in_valid: state_reg ← plaintext ^ key, key_reg ← key, rcnt ← 1, go to ROUND.
- ROUND, one round per cycle:
  - nk = key_expand(key_reg, rcon[rcnt]).
  - t = shift_rows(sub_bytes(state_reg)).
  - state_reg ← (rcnt==10 ? t : mix_columns(t)) ^ nk.
  - key_reg ← nk.
  - If rcnt==10, go to DONE and set rcnt ← 0. Otherwise rcnt ← rcnt+1.
- DONE:
  - out_valid=1. ciphertext=state_reg, held stable until out_ready.
  - On out_ready && !in_valid: go to IDLE.
  - On out_ready && in_valid: accept the new block in the same cycle (as in IDLE) and go directly to ROUND.
- in_ready = (fsm==IDLE) || (fsm==DONE && out_ready). The combinational path from out_ready to in_ready is intended.
- Inputs are ignored when no handshake occurs. plaintext/key need only be stable in the handshake cycle.
- out_valid never drops without out_ready (AXI-style rule).
- rcon table: 01,02,04,08,10,20,40,80,1b,36, indexed by rcnt-1.
- All XORs are 128-bit bitwise. No arithmetic beyond the 4-bit rcnt, which never exceeds 10.

## Timing
- Reset values: fsm=IDLE, state_reg=0, key_reg=0, rcnt=0, out_valid=0, ciphertext=0, round=0, busy=0. in_ready is 0 while rst is high and 1 in the first cycle after release.
- Reset mid-operation (ROUND or DONE) aborts immediately. The pending result is discarded and no out_valid pulse follows.
- Latency: with acceptance at edge E0, rounds execute on edges E1..E10 and out_valid is high in the cycle after E10. That is 10 cycles from the accept edge to out_valid.
- Back-to-back with out_ready tied high gives one block every 11 cycles. The DONE cycle overlaps the next acceptance.
- No output depends combinationally on plaintext/key. out_valid, ciphertext, round and busy are registered or decoded from registers.

## Structure
- Package aes_pkg holds:
  - typedef aes_state_t (logic [127:0]).
  - enum ctrl_state_t {IDLE, ROUND, DONE}.
  - localparam NR=10.
  - rcon lookup function.
  - sbox function shared by sub_bytes and the key expansion.
- Sub-module aes_key_expand_round: one-round AES-128 key schedule, combinational. Inputs are a 128-bit key and an 8-bit rcon; output is the next 128-bit key (RotWord/SubWord/XOR chain).
- The datapath reuses the existing sub_bytes, shift_rows and mix_columns modules, instantiated once each. The controller owns only the registers and the FSM.

## Test plan
- FIPS-197 App. B: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c → ciphertext 3925841d02dc09fbdc118597196a0b32, out_valid exactly 10 cycles after the accept edge. round steps 1..10, busy high for 10 cycles.
- FIPS-197 App. C.1: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f → 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-pressure: hold out_ready=0 for 20 cycles after completion → out_valid stays 1, ciphertext is constant, in_ready=0. Release → one transfer, then IDLE.
- Back-to-back: out_ready=1 and in_valid=1 continuously with C.1 then B vectors → both correct results, 11-cycle spacing, no dropped or duplicated block.
- Reset mid-round: assert rst asynchronously at round 5 (between edges) → all outputs go to reset values immediately with no clock. After release, a new C.1 block completes correctly.
- Idle noise: toggle plaintext/key with in_valid=0 → no state change, out_valid stays 0.
